mdu: RTL and testbench



---
 rtl/mdu_pkg.sv | 37 +++
 rtl/mdu_arith.sv | 55 +++++
 rtl/mdu.sv | 94 +++++++++
 tb/tb_mdu.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared op codes, widths, default latencies and payload types for the multiply/divide unit.
package mdu_pkg;

    localparam int unsigned OP_W            = 4;
    localparam int unsigned DATA_W          = 32;
    localparam int unsigned MULT_CYCLES_DEF = 5;
    localparam int unsigned DIV_CYCLES_DEF  = 10;

    localparam logic [OP_W-1:0] MDU_NONE  = OP_W'(0);
    localparam logic [OP_W-1:0] MDU_MULT  = OP_W'(1);
    localparam logic [OP_W-1:0] MDU_MULTU = OP_W'(2);
    localparam logic [OP_W-1:0] MDU_DIV   = OP_W'(3);
    localparam logic [OP_W-1:0] MDU_DIVU  = OP_W'(4);
    localparam logic [OP_W-1:0] MDU_MFHI  = OP_W'(5);
    localparam logic [OP_W-1:0] MDU_MFLO  = OP_W'(6);
    localparam logic [OP_W-1:0] MDU_MTHI  = OP_W'(7);
    localparam logic [OP_W-1:0] MDU_MTLO  = OP_W'(8);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } mdu_state_t;

    typedef struct packed {
        logic [DATA_W-1:0] hi;
        logic [DATA_W-1:0] lo;
    } hilo_t;

    function automatic logic is_long_op(input logic [OP_W-1:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU) || (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic logic is_div_op(input logic [OP_W-1:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

endpackage

// File: rtl/mdu_arith.sv
// Combinational 64-bit product and quotient/remainder for mult/multu/div/divu.
module mdu_arith
    import mdu_pkg::*;
(
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output hilo_t             res_c,
    output logic              div_zero_c
);

    logic [2*DATA_W-1:0] ext_a;
    logic [2*DATA_W-1:0] ext_b;
    logic [2*DATA_W-1:0] prod;
    logic                a_neg;
    logic                b_neg;
    logic [DATA_W-1:0]   mag_a;
    logic [DATA_W-1:0]   mag_b;
    logic [DATA_W-1:0]   divisor;
    logic [DATA_W-1:0]   quo;
    logic [DATA_W-1:0]   rem;

    // Signed division runs on magnitudes; 0x80000000 / -1 wraps back to 0x80000000 naturally.
    always_comb begin
        ext_a      = {{DATA_W{1'b0}}, src_a};
        ext_b      = {{DATA_W{1'b0}}, src_b};
        a_neg      = 1'b0;
        b_neg      = 1'b0;
        if (op == MDU_MULT) begin
            ext_a = {{DATA_W{src_a[DATA_W-1]}}, src_a};
            ext_b = {{DATA_W{src_b[DATA_W-1]}}, src_b};
        end
        if (op == MDU_DIV) begin
            a_neg = src_a[DATA_W-1];
            b_neg = src_b[DATA_W-1];
        end
        prod       = ext_a * ext_b;
        mag_a      = a_neg ? (-src_a) : src_a;
        mag_b      = b_neg ? (-src_b) : src_b;
        div_zero_c = (src_b == '0);
        divisor    = div_zero_c ? DATA_W'(1) : mag_b;
        quo        = mag_a / divisor;
        rem        = mag_a % divisor;
        if (a_neg ^ b_neg) quo = -quo;
        if (a_neg)         rem = -rem;

        res_c = '0;
        case (op)
            MDU_MULT, MDU_MULTU: res_c = '{hi: prod[2*DATA_W-1:DATA_W], lo: prod[DATA_W-1:0]};
            MDU_DIV,  MDU_DIVU:  res_c = '{hi: rem, lo: quo};
            default:             res_c = '0;
        endcase
    end

endmodule

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency mult/div sequencing, HI/LO ownership and mfhi/mflo read mux.
module mdu
    import mdu_pkg::*;
#(
    parameter int unsigned MULT_CYCLES = MULT_CYCLES_DEF,
    parameter int unsigned DIV_CYCLES  = DIV_CYCLES_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [OP_W-1:0]   op,
    input  logic [DATA_W-1:0] src_a,
    input  logic [DATA_W-1:0] src_b,
    output logic              busy,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int unsigned CNT_RAW_W  = $clog2(MAX_CYCLES + 1);
    localparam int unsigned CNT_W      = (CNT_RAW_W < 4) ? 4 : CNT_RAW_W;

    mdu_state_t        state;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] pend_hi;
    logic [DATA_W-1:0] pend_lo;
    hilo_t             arith_res_c;
    logic              div_zero_c;

    mdu_arith u_arith (
        .op         (op),
        .src_a      (src_a),
        .src_b      (src_b),
        .res_c      (arith_res_c),
        .div_zero_c (div_zero_c)
    );

    // Result is latched at issue; a divide by zero re-commits the current HI/LO.
    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            busy    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            pend_hi <= '0;
            pend_lo <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        if (is_long_op(op)) begin
                            if (is_div_op(op) && div_zero_c) begin
                                pend_hi <= hi;
                                pend_lo <= lo;
                            end else begin
                                pend_hi <= arith_res_c.hi;
                                pend_lo <= arith_res_c.lo;
                            end
                            cnt   <= is_div_op(op) ? CNT_W'(DIV_CYCLES) : CNT_W'(MULT_CYCLES);
                            busy  <= 1'b1;
                            state <= ST_RUN;
                        end else if (op == MDU_MTHI) begin
                            hi <= src_a;
                        end else if (op == MDU_MTLO) begin
                            lo <= src_a;
                        end
                    end
                end
                ST_RUN: begin
                    if (cnt == CNT_W'(1)) begin
                        hi    <= pend_hi;
                        lo    <= pend_lo;
                        cnt   <= '0;
                        busy  <= 1'b0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end
            endcase
        end
    end

    assign result = (op == MDU_MFHI) ? hi :
                    (op == MDU_MFLO) ? lo : '0;

endmodule

// File: tb/tb_mdu.sv
// Directed self-checking bench for mdu: latencies, HI/LO results, corners, reset abort, back-to-back issue.
module tb_mdu;
    import mdu_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [3:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        busy;
    logic [31:0] result;
    logic [31:0] hi;
    logic [31:0] lo;

    int n_chk  = 0;
    int n_pass = 0;

    mdu #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .op     (op),
        .src_a  (src_a),
        .src_b  (src_b),
        .busy   (busy),
        .result (result),
        .hi     (hi),
        .lo     (lo)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        else n_pass++;
    endtask

    // Caller sits at a negedge; drives one start cycle and returns at the following negedge.
    task automatic issue(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b);
        start = 1'b1;
        op    = o;
        src_a = a;
        src_b = b;
        @(negedge clk);
        start = 1'b0;
        op    = MDU_NONE;
    endtask

    // Counts negedges with busy high, bounded; returns at the negedge where busy has fallen.
    task automatic wait_idle(output int n);
        n = 0;
        while (busy === 1'b1 && n < 64) begin
            n++;
            @(negedge clk);
        end
    endtask

    task automatic long_op(input string tag, input logic [3:0] o, input logic [31:0] a,
                           input logic [31:0] b, input int cyc,
                           input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        int n;
        issue(o, a, b);
        wait_idle(n);
        chk({tag, " busy_cycles"}, 32'(n), 32'(cyc));
        chk({tag, " hi"}, hi, exp_hi);
        chk({tag, " lo"}, lo, exp_lo);
    endtask

    initial begin
        int n;
        reset = 1'b1;
        start = 1'b0;
        op    = MDU_NONE;
        src_a = '0;
        src_b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset hi", hi, 32'h0);
        chk("reset lo", lo, 32'h0);
        chk("reset result", result, 32'h0);

        long_op("mult",  MDU_MULT,  32'hFFFFFFFE, 32'h3, 5, 32'hFFFFFFFF, 32'hFFFFFFFA);
        long_op("multu", MDU_MULTU, 32'hFFFFFFFE, 32'h3, 5, 32'h00000002, 32'hFFFFFFFA);
        long_op("div",   MDU_DIV,   32'hFFFFFFF9, 32'h2, 10, 32'hFFFFFFFF, 32'hFFFFFFFD);
        long_op("divu",  MDU_DIVU,  32'h7,        32'h2, 10, 32'h1, 32'h3);
        long_op("div_ovf", MDU_DIV, 32'h80000000, 32'hFFFFFFFF, 10, 32'h0, 32'h80000000);

        // Divide by zero leaves preloaded HI/LO untouched
        issue(MDU_MTHI, 32'h11, 32'h0);
        issue(MDU_MTLO, 32'h22, 32'h0);
        long_op("div0", MDU_DIV, 32'h5, 32'h0, 10, 32'h11, 32'h22);

        // Unused op code is a no-op
        issue(4'd9, 32'h1234, 32'h5678);
        chk("op9 busy", 32'(busy), 32'd0);
        chk("op9 hi", hi, 32'h11);

        // MTHI/MTLO and MFHI/MFLO read mux
        issue(MDU_MTLO, 32'h0, 32'h0);
        issue(MDU_MTHI, 32'hDEADBEEF, 32'h0);
        chk("mthi busy", 32'(busy), 32'd0);
        op = MDU_MFLO;
        #1 chk("mflo result", result, 32'h0);
        op = MDU_MFHI;
        #1 chk("mfhi result", result, 32'hDEADBEEF);
        @(negedge clk);
        op = MDU_NONE;

        // MTLO while busy is ignored; MFHI during RUN shows the old HI
        issue(MDU_MULT, 32'h2, 32'h3);
        issue(MDU_MTLO, 32'h5555, 32'h0);
        chk("mtlo_busy lo", lo, 32'h0);
        op = MDU_MFHI;
        #1 chk("mfhi during run", result, 32'hDEADBEEF);
        op = MDU_NONE;
        wait_idle(n);
        chk("mtlo_busy cycles", 32'(n + 1), 32'd5);
        chk("mtlo_busy final hi", hi, 32'h0);
        chk("mtlo_busy final lo", lo, 32'h6);

        // Reset on the third busy cycle aborts with no commit
        issue(MDU_MULT, 32'h3, 32'h4);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        start = 1'b1;
        op    = MDU_MTHI;
        src_a = 32'hAAAA;
        @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        op    = MDU_NONE;
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort hi", hi, 32'h0);
        chk("abort lo", lo, 32'h0);
        repeat (8) @(negedge clk);
        chk("abort late lo", lo, 32'h0);
        chk("abort late busy", 32'(busy), 32'd0);

        // Back-to-back: new start in the cycle busy falls
        issue(MDU_MULT, 32'h5, 32'h6);
        wait_idle(n);
        chk("b2b mult cycles", 32'(n), 32'd5);
        chk("b2b mult lo", lo, 32'd30);
        issue(MDU_DIVU, 32'd100, 32'd7);
        chk("b2b div accepted", 32'(busy), 32'd1);
        wait_idle(n);
        chk("b2b div cycles", 32'(n), 32'd10);
        chk("b2b div hi", hi, 32'd2);
        chk("b2b div lo", lo, 32'd14);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
